// File: rtl/credit_pkg.sv
// credit_pkg: shared definitions for the credit-debtor slice.
//   - FSM state encodings and the state enum built from them
//   - SAT_ALL_ONES: all-ones pattern; modules slice it to their own
//     width to get the saturation value for the balance counter.
package credit_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_BACKOFF = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    COLLECT = ST_COLLECT,
    BACKOFF = ST_BACKOFF
  } state_t;

  localparam int SAT_MAX_WIDTH = 64;
  localparam logic [SAT_MAX_WIDTH-1:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/credit_backoff_timer.sv
// credit_backoff_timer: loadable down-counter with a done pulse.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        load load_value and start counting
//   load_value  first count value after load (counts down to 0)
//   done        high for the one cycle the running count sits at 0
module credit_backoff_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          done
);

  logic [CW-1:0] count_reg;
  logic          active_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      count_reg  <= load_value;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (count_reg == '0) begin
        active_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign done = active_reg && (count_reg == '0);

endmodule

// File: rtl/credit_debtor.sv
// credit_debtor: upstream end of a credit-based flow-control link.
// Holds the spendable credit balance and requests more credit from the
// creditor over the borrow/grant/credit handshake when the balance is low.
// Optional feature macro: CREDIT_DEBTOR_BACKOFF_EN -- after a zero-credit
// grant, wait BACKOFF_CYCLES cycles before a new request may be made.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   borrow    out: credit request (Moore, from state register only)
//   grant     in : creditor accepts request, sampled while borrow=1
//   credit    in : credit amount, valid the cycle after grant
//   consume   in : sender transmits one item this cycle
//   ready     out: balance != 0
//   balance   out: current credit balance
//   error     out: sticky; consume while !ready or balance overflow
module credit_debtor
  import credit_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CREDIT_WIDTH    = 8,
  parameter int LOW_WATERMARK   = 4,
  parameter int INITIAL_BALANCE = 0,
  parameter int BACKOFF_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    borrow,
  input  logic                    grant,
  input  logic [CREDIT_WIDTH-1:0] credit,
  input  logic                    consume,
  output logic                    ready,
  output logic [WIDTH-1:0]        balance,
  output logic                    error
);

  localparam logic [WIDTH-1:0] BAL_SAT  = SAT_ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] BAL_INIT = WIDTH'(INITIAL_BALANCE);
  localparam logic [WIDTH-1:0] BAL_LOW  = WIDTH'(LOW_WATERMARK);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] balance_reg, balance_next;
  logic             error_reg, error_next;
  logic             spend;
  logic             bad_consume;
  logic [WIDTH:0]   sum;

  assign ready       = (balance_reg != '0);
  assign spend       = consume & ready;
  assign bad_consume = consume & ~ready;

  // One extra bit so an overflowing credit return is detectable; spend can
  // only be 1 when the balance is non-zero, so this never underflows.
  assign sum = {1'b0, balance_reg} + (WIDTH+1)'(credit) - (WIDTH+1)'(spend);

`ifdef CREDIT_DEBTOR_BACKOFF_EN
  localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

  logic backoff_load;
  logic backoff_done;

  // Loaded on the edge that leaves COLLECT, so the count is BACKOFF_CYCLES-1
  // in the first BACKOFF cycle and 0 (done) in the last one.
  assign backoff_load = (state_reg == COLLECT) && (credit == '0);

  credit_backoff_timer #(
    .CW(BW)
  ) u_backoff_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (backoff_load),
    .load_value (BW'(BACKOFF_CYCLES - 1)),
    .done       (backoff_done)
  );
`endif

  always_comb begin
    state_next   = state_reg;
    balance_next = balance_reg;
    error_next   = error_reg | bad_consume;

    case (state_reg)
      IDLE: begin
        if (balance_reg <= BAL_LOW) state_next = REQ;
      end
      REQ: begin
        if (grant) state_next = COLLECT;
      end
      COLLECT: begin
`ifdef CREDIT_DEBTOR_BACKOFF_EN
        state_next = (credit == '0) ? BACKOFF : IDLE;
`else
        state_next = IDLE;
`endif
      end
      BACKOFF: begin
`ifdef CREDIT_DEBTOR_BACKOFF_EN
        if (backoff_done) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase

    // Credit is only ever taken in COLLECT; anything on the credit bus in
    // other states (including after a reset mid-transaction) is ignored.
    if (state_reg == COLLECT) begin
      if (sum[WIDTH]) begin
        balance_next = BAL_SAT;
        error_next   = 1'b1;
      end else begin
        balance_next = sum[WIDTH-1:0];
      end
    end else if (spend) begin
      balance_next = balance_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      balance_reg <= BAL_INIT;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      balance_reg <= balance_next;
      error_reg   <= error_next;
    end
  end

  assign borrow  = (state_reg == REQ);
  assign balance = balance_reg;
  assign error   = error_reg;

endmodule

// File: tb/tb_credit_debtor.sv
module tb_credit_debtor;

  logic        clk;
  logic        rst;
  logic        borrow, grant, consume, ready, error;
  logic [7:0]  credit;
  logic [15:0] balance;

  // Second instance: 8-bit balance whose watermark sits near the top so a
  // request can be made while the balance is high enough to overflow.
  logic        borrow2, grant2, consume2, ready2, error2;
  logic [7:0]  credit2;
  logic [7:0]  balance2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_bal;
  bit exp_err;
  int sb_q[$];

  credit_debtor #(
    .WIDTH(16), .CREDIT_WIDTH(8), .LOW_WATERMARK(4),
    .INITIAL_BALANCE(0), .BACKOFF_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .borrow(borrow), .grant(grant), .credit(credit),
    .consume(consume), .ready(ready), .balance(balance), .error(error)
  );

  credit_debtor #(
    .WIDTH(8), .CREDIT_WIDTH(8), .LOW_WATERMARK(250),
    .INITIAL_BALANCE(250), .BACKOFF_CYCLES(16)
  ) dut2 (
    .clk(clk), .rst(rst), .borrow(borrow2), .grant(grant2), .credit(credit2),
    .consume(consume2), .ready(ready2), .balance(balance2), .error(error2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic wait_borrow(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (borrow === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    n_cmp++;
    n_err++;
    $display("FAIL borrow_timeout: got borrow=0 for 50 cycles expected 1");
  endtask

  task automatic consume_cycle();
    consume = 1'b1;
    if (exp_bal != 0) exp_bal--;
    else exp_err = 1'b1;
    step();
    consume = 1'b0;
  endtask

  // Full handshake: grant in cycle G, credit in G+1, balance checked in G+2.
  task automatic transact(input int c, input bit cons_req, input bit cons_col,
                          input string tag);
    bit ok;
    int s;
    int got;
    wait_borrow(ok);
    if (!ok) return;
    grant   = 1'b1;
    consume = cons_req;
    if (cons_req) begin
      if (exp_bal != 0) exp_bal--;
      else exp_err = 1'b1;
    end
    step();
    grant   = 1'b0;
    consume = cons_col;
    credit  = 8'(c);
    chk({tag, "_borrow_drop"}, int'(borrow), 0);
    chk({tag, "_bal_collect"}, int'(balance), exp_bal);
    s = exp_bal + c;
    if (cons_col) begin
      if (exp_bal != 0) s--;
      else exp_err = 1'b1;
    end
    if (s > 65535) begin
      s = 65535;
      exp_err = 1'b1;
    end
    sb_q.push_back(s);
    step();
    consume = 1'b0;
    credit  = 8'($urandom_range(1, 255));
    exp_bal = sb_q.pop_front();
    got = int'(balance);
    chk({tag, "_balance"}, got, exp_bal);
    chk({tag, "_error"}, int'(error), int'(exp_err));
    chk({tag, "_borrow_idle"}, int'(borrow), 0);
    $display("txn %s: credit=%0d balance=%0d expected=%0d error=%0b",
             tag, c, got, exp_bal, error);
  endtask

  task automatic test_reset();
    step();
    step();
    chk("reset_borrow", int'(borrow), 0);
    chk("reset_balance", int'(balance), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_balance2", int'(balance2), 250);
    rst = 1'b0;
    exp_bal = 0;
    exp_err = 1'b0;
    chk("reset_borrow_c1", int'(borrow), 0);
    step();
    chk("reset_borrow_c2", int'(borrow), 1);
    transact(8, 1'b0, 1'b0, "reset_grant");
    chk("reset_ready_after", int'(ready), 1);
    step();
    chk("reset_idle_no_borrow", int'(borrow), 0);
  endtask

  task automatic test_watermark();
    consume_cycle();
    consume_cycle();
    chk("wm_start_6", int'(balance), 6);
    for (int i = 0; i < 5; i++) begin
      consume_cycle();
      chk($sformatf("wm_balance_%0d", i), int'(balance), exp_bal);
      // Balance first reaches 4 after the 2nd consume; borrow follows a cycle later.
      chk($sformatf("wm_borrow_%0d", i), int'(borrow), (i >= 2) ? 1 : 0);
      $display("txn consume %0d: balance=%0d borrow=%0b", i, balance, borrow);
    end
    chk("wm_final_1", int'(balance), 1);
    chk("wm_no_error", int'(error), 0);
  endtask

  task automatic test_back_to_back();
    // Consume in the grant cycle: decrement now, credit next cycle.
    transact(2, 1'b1, 1'b0, "req_consume");
    step();
    chk("rerequest_spacing", int'(borrow), 1);
  endtask

  task automatic test_collect_consume();
    transact(10, 1'b0, 1'b1, "collect_consume");
    chk("collect_consume_11", int'(balance), 11);
  endtask

  task automatic test_error();
    while (exp_bal > 0) consume_cycle();
    chk("err_drained", int'(balance), 0);
    chk("err_not_ready", int'(ready), 0);
    chk("err_clear_before", int'(error), 0);
    consume_cycle();
    chk("err_set", int'(error), 1);
    chk("err_balance_0", int'(balance), 0);
    for (int i = 0; i < 3; i++) step();
    chk("err_sticky", int'(error), 1);
    $display("txn underflow: balance=%0d error=%0b", balance, error);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_bal = 0;
    exp_err = 1'b0;
    chk("err_rst_clears", int'(error), 0);
  endtask

  task automatic test_zero_credit();
    transact(0, 1'b0, 1'b0, "zero_credit");
`ifdef CREDIT_DEBTOR_BACKOFF_EN
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("backoff_quiet_%0d", k), int'(borrow), 0);
    end
    step();
    chk("backoff_rerequest", int'(borrow), 1);
`else
    step();
    chk("zero_rerequest", int'(borrow), 1);
`endif
    transact(8, 1'b0, 1'b0, "refill");
  endtask

  task automatic test_saturation();
    int s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (borrow2 === 1'b1) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL sat_borrow_timeout: got borrow2=0 expected 1");
      return;
    end
    grant2 = 1'b1;
    step();
    grant2  = 1'b0;
    credit2 = 8'd10;
    s = 250 + 10;
    sb_q.push_back((s > 255) ? 255 : s);
    step();
    credit2 = 8'd0;
    s = sb_q.pop_front();
    chk("sat_balance", int'(balance2), s);
    chk("sat_error", int'(error2), 1);
    chk("sat_ready", int'(ready2), 1);
    $display("txn saturate: credit=10 balance=%0d expected=%0d error=%0b",
             balance2, s, error2);
  endtask

  initial begin
    rst = 1'b1;
    grant = 1'b0; consume = 1'b0; credit = 8'd0;
    grant2 = 1'b0; consume2 = 1'b0; credit2 = 8'd0;
    exp_bal = 0;
    exp_err = 1'b0;
    test_reset();
    test_watermark();
    test_back_to_back();
    test_collect_consume();
    test_error();
    test_zero_credit();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/credit_debtor.md
# credit_debtor

Upstream end of the credit-based flow-control link: it holds the local credit balance a sender may spend and requests more credit from the downstream creditor when the balance runs low. Each sent item consumes one credit. It sits next to the transmit FIFO of a link endpoint and gates its send path. It talks to the creditor over the borrow/grant/credit handshake.

## Interface
Parameters:
- WIDTH, 16: width of the local balance counter.
- CREDIT_WIDTH, 8: width of the credit value returned by the creditor.
- LOW_WATERMARK, 4: a request is issued when the balance is <= this value.
- INITIAL_BALANCE, 0: balance loaded at reset.
- BACKOFF_CYCLES, 16: idle cycles after a zero-credit grant (only with the backoff feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- borrow  out  1  credit request to the creditor.
- grant  in  1  creditor accepts the request; sampled in the same cycle as borrow.
- credit  in  CREDIT_WIDTH  credit amount; valid the cycle after grant.
- consume  in  1  sender transmits one item this cycle.
- ready  out  1  balance != 0; sender may consume.
- balance  out  WIDTH  current credit balance.
- error  out  1  sticky: consume while !ready, or balance overflow.

## Operation
- FSM states: IDLE, REQ, COLLECT, and BACKOFF when the backoff feature is compiled in.
- IDLE: if balance <= LOW_WATERMARK, go to REQ next cycle.
- REQ: borrow=1. On grant=1, go to COLLECT. Otherwise stay in REQ and hold borrow.
- COLLECT: balance <= balance + credit - (consume & ready).
  - If credit == 0 and the backoff feature is in, go to BACKOFF.
  - Otherwise go to IDLE.
- BACKOFF: a counter runs from BACKOFF_CYCLES-1 down to 0, then the FSM goes to IDLE.
- borrow is decoded from the state register only (Moore); it has no combinational path from any input.
- Consume outside COLLECT: if ready, balance decrements by 1.
- Consume while !ready: balance is unchanged and error is set.
- Arithmetic:
  - The sum is computed WIDTH+1 bits wide, with credit zero-extended.
  - If the sum exceeds 2^WIDTH-1, balance saturates to all-ones and error is set.
- error stays set until rst.
- Reset values: state IDLE, borrow 0, balance INITIAL_BALANCE, ready (INITIAL_BALANCE != 0), error 0, backoff counter 0.
- Reset mid-operation, including during REQ or COLLECT, abandons the transaction. Any credit arriving afterwards is ignored.

## Timing
- Request latency: balance reaches the watermark in cycle N; borrow=1 in cycle N+1.
- Handshake: a grant sampled in cycle G means credit is sampled in cycle G+1 (COLLECT).
  - The new balance is visible in cycle G+2.
  - borrow drops in cycle G+1.
- ready reflects the registered balance. A consume in cycle N affects ready from cycle N+1.
- Minimum spacing between two requests:
  - 3 cycles (REQ, COLLECT, IDLE) without backoff.
  - 3 + BACKOFF_CYCLES cycles after a zero-credit grant with backoff.
- Simultaneous grant and consume in REQ: the decrement applies in the same cycle; the credit is added in COLLECT.

## Configuration
- CREDIT_DEBTOR_BACKOFF_EN defined: a zero credit in COLLECT enters BACKOFF for BACKOFF_CYCLES cycles before IDLE can re-request.
- Undefined: no BACKOFF state and no counter. A zero-credit COLLECT returns to IDLE, and borrow reasserts 2 cycles later if the balance is still at or below the watermark.

## Structure
- Shared package credit_pkg holds:
  - the FSM state encoding localparams (IDLE, REQ, COLLECT, BACKOFF);
  - a helper constant for the saturation value.
- One sub-module, credit_backoff_timer: load, count down, done pulse. It is instantiated only under CREDIT_DEBTOR_BACKOFF_EN.

## Test plan
- Reset with INITIAL_BALANCE=0:
  - borrow=1 in the 2nd cycle after rst drops.
  - Grant, then credit=8 the next cycle → balance=8 two cycles after grant, ready=1, state IDLE.
- Balance 6, five consecutive consumes → balance 5 then 4. borrow rises the cycle after balance reaches 4; balance reaches 1 with no error.
- Consume during COLLECT with balance=2 and credit=10 → balance=11.
- balance=0 and consume=1 → error=1 and stays 1, balance remains 0. rst clears error.
- WIDTH=8, balance=250, credit=10 → balance=255 (saturated), error=1.
- With CREDIT_DEBTOR_BACKOFF_EN and BACKOFF_CYCLES=16, a grant with credit=0 → no borrow for 16 cycles after COLLECT, then borrow 1 cycle after IDLE. Without the macro, borrow reasserts 2 cycles after COLLECT.
